mem_stage: RTL and testbench

//  Memory-access stage directly downstream of ex. Latches the ex results and runs

---
 rtl/mem_stage_pkg.sv | 56 +++++
 rtl/mem_align.sv | 58 +++++
 rtl/mem_stage.sv | 151 +++++++++++++++
 tb/tb_mem_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: aluop codes for the
// load/store family, bus widths, FSM encodings and small decode helpers.
package mem_stage_pkg;

   // Width of the aluop bus (`AluOpBus).
   localparam int ALU_OP_W  = 8;
   // Width of the data-bus byte-enable field (`DBusBeBus).
   localparam int DBUS_BE_W = 4;

   // Non-memory codes the stage passes straight through.
   localparam logic [ALU_OP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
   localparam logic [ALU_OP_W-1:0] EXE_ADD_OP = 8'b0010_0000;

   // Load/store codes, shared with ex.
   localparam logic [ALU_OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [ALU_OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [ALU_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [ALU_OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [ALU_OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [ALU_OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [ALU_OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [ALU_OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

   // Memory FSM encodings.
   localparam logic [0:0] MEM_IDLE = 1'b0;
   localparam logic [0:0] MEM_BUSY = 1'b1;

   function automatic logic is_load(input logic [ALU_OP_W-1:0] op);
      case (op)
         EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load = 1'b1;
         default:                                                is_load = 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input logic [ALU_OP_W-1:0] op);
      case (op)
         EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_store = 1'b1;
         default:                         is_store = 1'b0;
      endcase
   endfunction

   function automatic logic is_mem_op(input logic [ALU_OP_W-1:0] op);
      is_mem_op = is_load(op) || is_store(op);
   endfunction

   // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes never misalign.
   function automatic logic is_misaligned(input logic [ALU_OP_W-1:0] op,
                                          input logic [1:0]          addr_lo);
      case (op)
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: is_misaligned = addr_lo[0];
         EXE_LW_OP, EXE_SW_OP:             is_misaligned = (addr_lo != 2'b00);
         default:                          is_misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational data-path helper for mem_stage: store byte-lane steering and
// load byte/half extraction with sign or zero extension.
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [ALU_OP_W-1:0]  st_op,
   input  logic [1:0]           st_addr_lo,
   input  logic [31:0]          st_data,
   output logic [DBUS_BE_W-1:0] st_be,
   output logic [31:0]          st_wdata,
   input  logic [ALU_OP_W-1:0]  ld_op,
   input  logic [1:0]           ld_addr_lo,
   input  logic [31:0]          ld_rdata,
   output logic [31:0]          ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Store lanes: replicate the narrow datum across the word, enable only its lanes.
   always_comb begin
      st_be    = 4'hF;
      st_wdata = st_data;
      case (st_op)
         EXE_SB_OP: begin
            st_be    = 4'b0001 << st_addr_lo;
            st_wdata = {4{st_data[7:0]}};
         end
         EXE_SH_OP: begin
            st_be    = 4'b0011 << st_addr_lo;
            st_wdata = {2{st_data[15:0]}};
         end
         default: begin
            st_be    = 4'hF;
            st_wdata = st_data;
         end
      endcase
   end

   // Load extract: pick the addressed byte/half, then extend according to the op.
   always_comb begin
      case (ld_addr_lo)
         2'd0:    ld_byte = ld_rdata[7:0];
         2'd1:    ld_byte = ld_rdata[15:8];
         2'd2:    ld_byte = ld_rdata[23:16];
         default: ld_byte = ld_rdata[31:24];
      endcase
      ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
      case (ld_op)
         EXE_LB_OP:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         EXE_LBU_OP: ld_data = {24'h000000, ld_byte};
         EXE_LH_OP:  ld_data = {{16{ld_half[15]}}, ld_half};
         EXE_LHU_OP: ld_data = {16'h0000, ld_half};
         default:    ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: latches ex results, runs load/store transactions on
// the req/ack data bus, flags misaligned accesses and aborts on ack timeout.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           ex_wd_i,
   input  logic                 ex_wreg_i,
   input  logic [31:0]          ex_wdata_i,
   input  logic [ALU_OP_W-1:0]  ex_aluop_i,
   input  logic [31:0]          ex_mem_addr_i,
   input  logic [31:0]          ex_reg2_i,
   output logic                 stallreq_o,
   output logic                 dbus_req_o,
   output logic                 dbus_we_o,
   output logic [31:0]          dbus_addr_o,
   output logic [DBUS_BE_W-1:0] dbus_be_o,
   output logic [31:0]          dbus_wdata_o,
   input  logic                 dbus_ack_i,
   input  logic [31:0]          dbus_rdata_i,
   output logic [4:0]           mem_wd_o,
   output logic                 mem_wreg_o,
   output logic [31:0]          mem_wdata_o,
   output logic                 misalign_o,
   output logic                 bus_err_o
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [0:0]           state;
   logic [CNT_W-1:0]     tmo_cnt;
   logic [ALU_OP_W-1:0]  op_q;
   logic [4:0]           wd_q;
   logic                 wreg_q;
   logic [1:0]           addr_lo_q;

   logic                 ex_mem;
   logic                 ex_mis;
   logic                 issue;
   logic                 timeout_hit;
   logic [DBUS_BE_W-1:0] st_be;
   logic [31:0]          st_wdata;
   logic [31:0]          ld_data;

   mem_align u_align (
      .st_op      (ex_aluop_i),
      .st_addr_lo (ex_mem_addr_i[1:0]),
      .st_data    (ex_reg2_i),
      .st_be      (st_be),
      .st_wdata   (st_wdata),
      .ld_op      (op_q),
      .ld_addr_lo (addr_lo_q),
      .ld_rdata   (dbus_rdata_i),
      .ld_data    (ld_data)
   );

   // Decode the incoming ex op and the abort condition for the current cycle.
   always_comb begin
      ex_mem      = is_mem_op(ex_aluop_i);
      ex_mis      = ex_mem && is_misaligned(ex_aluop_i, ex_mem_addr_i[1:0]);
      issue       = (state == MEM_IDLE) && ex_mem && !ex_mis;
      timeout_hit = 1'b0;
      if (TIMEOUT != 0) begin
         timeout_hit = (state == MEM_BUSY) && !dbus_ack_i &&
                       (tmo_cnt == CNT_W'(TIMEOUT - 1));
      end
   end

   // Hold upstream while a request is being issued or is outstanding; ex may
   // advance in the very cycle the ack arrives.
   always_comb begin
      stallreq_o = 1'b0;
      if (!rst) begin
         stallreq_o = (state == MEM_IDLE) ? issue : !dbus_ack_i;
      end
   end

   // FSM, bus request latches, timeout counter and the mem_wb-facing registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= MEM_IDLE;
         tmo_cnt      <= '0;
         op_q         <= '0;
         wd_q         <= '0;
         wreg_q       <= 1'b0;
         addr_lo_q    <= '0;
         dbus_req_o   <= 1'b0;
         dbus_we_o    <= 1'b0;
         dbus_addr_o  <= '0;
         dbus_be_o    <= '0;
         dbus_wdata_o <= '0;
         mem_wd_o     <= '0;
         mem_wreg_o   <= 1'b0;
         mem_wdata_o  <= '0;
         misalign_o   <= 1'b0;
         bus_err_o    <= 1'b0;
      end else begin
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
         case (state)
            MEM_IDLE: begin
               if (!ex_mem) begin
                  mem_wd_o    <= ex_wd_i;
                  mem_wreg_o  <= ex_wreg_i;
                  mem_wdata_o <= ex_wdata_i;
               end else if (ex_mis) begin
                  misalign_o <= 1'b1;
                  mem_wd_o   <= ex_wd_i;
                  mem_wreg_o <= 1'b0;
               end else begin
                  state        <= MEM_BUSY;
                  tmo_cnt      <= '0;
                  op_q         <= ex_aluop_i;
                  wd_q         <= ex_wd_i;
                  wreg_q       <= ex_wreg_i;
                  addr_lo_q    <= ex_mem_addr_i[1:0];
                  dbus_req_o   <= 1'b1;
                  dbus_we_o    <= is_store(ex_aluop_i);
                  dbus_addr_o  <= {ex_mem_addr_i[31:2], 2'b00};
                  dbus_be_o    <= st_be;
                  dbus_wdata_o <= st_wdata;
                  mem_wreg_o   <= 1'b0;
               end
            end
            default: begin
               if (dbus_ack_i) begin
                  state      <= MEM_IDLE;
                  dbus_req_o <= 1'b0;
                  mem_wd_o   <= wd_q;
                  mem_wreg_o <= wreg_q && is_load(op_q);
                  if (is_load(op_q)) begin
                     mem_wdata_o <= ld_data;
                  end
               end else if (timeout_hit) begin
                  state      <= MEM_IDLE;
                  dbus_req_o <= 1'b0;
                  bus_err_o  <= 1'b1;
                  mem_wreg_o <= 1'b0;
               end else begin
                  tmo_cnt    <= tmo_cnt + 1'b1;
                  mem_wreg_o <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// load/store/ALU traffic checked against an arithmetic reference model.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ex_wd_i;
   logic        ex_wreg_i;
   logic [31:0] ex_wdata_i;
   logic [7:0]  ex_aluop_i;
   logic [31:0] ex_mem_addr_i;
   logic [31:0] ex_reg2_i;
   logic        stallreq_o;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [3:0]  dbus_be_o;
   logic [31:0] dbus_wdata_o;
   logic        dbus_ack_i;
   logic [31:0] dbus_rdata_i;
   logic [4:0]  mem_wd_o;
   logic        mem_wreg_o;
   logic [31:0] mem_wdata_o;
   logic        misalign_o;
   logic        bus_err_o;

   int tests = 0;
   int fails = 0;

   mem_stage #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
      .ex_aluop_i(ex_aluop_i), .ex_mem_addr_i(ex_mem_addr_i), .ex_reg2_i(ex_reg2_i),
      .stallreq_o(stallreq_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
      .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
      .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
      .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic bit m_load(input logic [7:0] op);
      return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
             op == EXE_LHU_OP || op == EXE_LW_OP;
   endfunction

   function automatic bit m_store(input logic [7:0] op);
      return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
   endfunction

   function automatic int m_size(input logic [7:0] op);
      if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
      if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
      return 4;
   endfunction

   function automatic bit m_misaligned(input logic [7:0] op, input logic [31:0] addr);
      return (addr % m_size(op)) != 0;
   endfunction

   function automatic logic [31:0] m_be(input logic [7:0] op, input logic [31:0] addr);
      if (op == EXE_SB_OP) return 32'd1 << (addr % 4);
      if (op == EXE_SH_OP) return 32'd3 << (addr % 4);
      return 32'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] rs2);
      if (op == EXE_SB_OP) return (rs2 & 32'hFF) * 32'h0101_0101;
      if (op == EXE_SH_OP) return (rs2 & 32'hFFFF) * 32'h0001_0001;
      return rs2;
   endfunction

   function automatic logic [31:0] m_ldata(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
      logic [31:0] w, b, h;
      w = rdata >> (8 * (addr % 4));
      b = w & 32'hFF;
      h = w & 32'hFFFF;
      if (op == EXE_LB_OP)  return b - ((b & 32'h80) << 1);
      if (op == EXE_LBU_OP) return b;
      if (op == EXE_LH_OP)  return h - ((h & 32'h8000) << 1);
      if (op == EXE_LHU_OP) return h;
      return rdata;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop();
      ex_aluop_i    = EXE_NOP_OP;
      ex_wd_i       = '0;
      ex_wreg_i     = 1'b0;
      ex_wdata_i    = '0;
      ex_mem_addr_i = '0;
      ex_reg2_i     = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall"},  32'(stallreq_o),  32'd0);
      chk({tag, "_req"},    32'(dbus_req_o),  32'd0);
      chk({tag, "_we"},     32'(dbus_we_o),   32'd0);
      chk({tag, "_addr"},   dbus_addr_o,      32'd0);
      chk({tag, "_be"},     32'(dbus_be_o),   32'd0);
      chk({tag, "_wdat"},   dbus_wdata_o,     32'd0);
      chk({tag, "_wd"},     32'(mem_wd_o),    32'd0);
      chk({tag, "_wreg"},   32'(mem_wreg_o),  32'd0);
      chk({tag, "_mwdata"}, mem_wdata_o,      32'd0);
      chk({tag, "_mis"},    32'(misalign_o),  32'd0);
      chk({tag, "_berr"},   32'(bus_err_o),   32'd0);
   endtask

   // Non-memory op: one-cycle pass-through.
   task automatic do_alu(input logic [4:0] wd, input logic [31:0] wdata, input logic wreg);
      ex_aluop_i = EXE_ADD_OP; ex_wd_i = wd; ex_wreg_i = wreg; ex_wdata_i = wdata;
      ex_mem_addr_i = $urandom; ex_reg2_i = $urandom;
      #1;
      chk("alu_stall", 32'(stallreq_o), 32'd0);
      chk("alu_req",   32'(dbus_req_o), 32'd0);
      tick();
      chk("alu_wdata", mem_wdata_o,      wdata);
      chk("alu_wreg",  32'(mem_wreg_o),  32'(wreg));
      chk("alu_wd",    32'(mem_wd_o),    32'(wd));
      chk("alu_mis",   32'(misalign_o),  32'd0);
      chk("alu_berr",  32'(bus_err_o),   32'd0);
      set_nop();
   endtask

   // Memory op with the ack arriving after `lat` idle BUSY cycles (lat < 4).
   task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input logic [4:0] wd, input int lat);
      int stall_cnt;
      ex_aluop_i = op; ex_wd_i = wd; ex_wreg_i = m_load(op); ex_wdata_i = $urandom;
      ex_mem_addr_i = addr; ex_reg2_i = rs2;
      #1;
      if (m_misaligned(op, addr)) begin
         chk("mis_stall", 32'(stallreq_o), 32'd0);
         tick();
         chk("mis_pulse", 32'(misalign_o), 32'd1);
         chk("mis_req",   32'(dbus_req_o), 32'd0);
         chk("mis_wreg",  32'(mem_wreg_o), 32'd0);
         set_nop();
         return;
      end
      stall_cnt = 0;
      chk("iss_stall", 32'(stallreq_o), 32'd1);
      stall_cnt++;
      tick();
      chk("iss_req",  32'(dbus_req_o), 32'd1);
      chk("iss_we",   32'(dbus_we_o),  32'(m_store(op)));
      chk("iss_addr", dbus_addr_o,     addr & 32'hFFFF_FFFC);
      chk("iss_be",   32'(dbus_be_o),  m_be(op, addr));
      chk("iss_bubble", 32'(mem_wreg_o), 32'd0);
      if (m_store(op)) chk("iss_wdata", dbus_wdata_o, m_wdata(op, rs2));
      for (int i = 0; i < lat; i++) begin
         dbus_ack_i = 1'b0;
         #1;
         if (stallreq_o) stall_cnt++;
         tick();
         chk("busy_req",  32'(dbus_req_o), 32'd1);
         chk("busy_addr", dbus_addr_o,     addr & 32'hFFFF_FFFC);
         chk("busy_be",   32'(dbus_be_o),  m_be(op, addr));
      end
      dbus_ack_i = 1'b1; dbus_rdata_i = rdata;
      #1;
      chk("ack_stall", 32'(stallreq_o), 32'd0);
      chk("stall_cycles", 32'(stall_cnt), 32'(lat + 1));
      tick();
      dbus_ack_i = 1'b0; dbus_rdata_i = $urandom;
      chk("done_req",  32'(dbus_req_o), 32'd0);
      chk("done_wreg", 32'(mem_wreg_o), 32'(m_load(op)));
      chk("done_berr", 32'(bus_err_o),  32'd0);
      if (m_load(op)) begin
         chk("done_wd",    32'(mem_wd_o), 32'(wd));
         chk("load_data",  mem_wdata_o,   m_ldata(op, addr, rdata));
      end
      set_nop();
   endtask

   logic [7:0] op_tab [9] = '{EXE_ADD_OP, EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                              EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

   initial begin
      int n;
      logic [7:0]  rop;
      logic [31:0] raddr;
      rst = 1'b1; dbus_ack_i = 1'b0; dbus_rdata_i = '0;
      set_nop();
      tick(); tick();
      chk_all_zero("reset");
      rst = 1'b0;

      // ALU pass-through
      do_alu(5'd5, 32'h0000_1234, 1'b1);
      // signed byte load from the top lane, ack two cycles after req
      do_mem(EXE_LB_OP, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 5'd7, 2);
      // halfword store into the upper lanes
      do_mem(EXE_SH_OP, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 5'd0, 0);
      // misaligned word
      do_mem(EXE_LW_OP, 32'h0000_0101, 32'h0, 32'h0, 5'd3, 0);
      tick();
      chk("mis_clear", 32'(misalign_o), 32'd0);
      // ack in the last allowed cycle beats the timeout
      do_mem(EXE_LW_OP, 32'h0000_0700, 32'h0, 32'h1122_3344, 5'd9, 3);

      // timeout: never ack
      ex_aluop_i = EXE_LW_OP; ex_mem_addr_i = 32'h0000_0400; ex_wd_i = 5'd4; ex_wreg_i = 1'b1;
      #1;
      chk("tmo_stall0", 32'(stallreq_o), 32'd1);
      tick();
      n = 0;
      while (dbus_req_o && n < 10) begin
         chk("tmo_stall", 32'(stallreq_o), 32'd1);
         n++;
         tick();
      end
      chk("tmo_req_cycles", 32'(n), 32'd4);
      chk("tmo_berr",  32'(bus_err_o),  32'd1);
      chk("tmo_wreg",  32'(mem_wreg_o), 32'd0);
      set_nop();
      tick();
      chk("tmo_berr_clear", 32'(bus_err_o), 32'd0);
      do_alu(5'd6, 32'hCAFE_0001, 1'b1);

      // reset in the 2nd BUSY cycle, late ack ignored
      ex_aluop_i = EXE_LW_OP; ex_mem_addr_i = 32'h0000_0500; ex_wd_i = 5'd2; ex_wreg_i = 1'b1;
      tick();
      tick();
      chk("rst_busy_req", 32'(dbus_req_o), 32'd1);
      rst = 1'b1;
      tick();
      set_nop();
      #1;
      chk_all_zero("rst_busy");
      rst = 1'b0;
      dbus_ack_i = 1'b1; dbus_rdata_i = 32'h5555_AAAA;
      tick();
      dbus_ack_i = 1'b0;
      chk("late_ack_req",  32'(dbus_req_o),  32'd0);
      chk("late_ack_wreg", 32'(mem_wreg_o),  32'd0);
      chk("late_ack_data", mem_wdata_o,      32'd0);
      do_mem(EXE_LBU_OP, 32'h0000_0600, 32'h0, 32'h0000_00FF, 5'd1, 1);

      // randomized traffic
      for (int k = 0; k < 60; k++) begin
         rop   = op_tab[$urandom_range(0, 8)];
         raddr = $urandom;
         if (rop == EXE_ADD_OP)
            do_alu(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
         else
            do_mem(rop, raddr, $urandom, $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 3));
      end
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
